onehot_scan_decoder: RTL and testbench

//  Parametrised, registered binary-to-one-hot decoder. It replaces the fixed

---
 rtl/onehot_scan_decoder_pkg.sv | 27 ++
 rtl/onehot_scan_decoder_tick_gen.sv | 42 ++++
 rtl/onehot_scan_decoder.sv | 96 +++++++++
 tb/tb_onehot_scan_decoder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_scan_decoder_pkg.sv
// Shared constants and helpers for the one-hot scan decoder: mode encodings,
// a ceil-log2 sizing helper and a wide one-hot builder (element 0 leftmost).
package onehot_scan_decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest one-hot the helper can build; callers keep only the first NUM_OUT elements.
  localparam int MAX_OUT = 64;

  function automatic int clog2(input int unsigned value);
    int          width;
    int unsigned v;
    width = 0;
    v     = value - 1;
    while (v > 0) begin
      width++;
      v = v >> 1;
    end
    return (width < 1) ? 1 : width;
  endfunction

  function automatic logic [0:MAX_OUT-1] onehot(input int unsigned idx);
    return {1'b1, {(MAX_OUT-1){1'b0}}} >> idx;
  endfunction

endpackage

// File: rtl/onehot_scan_decoder_tick_gen.sv
// Scan prescaler: counts 0..PRESCALE-1 while run is high and pulses tick
// combinationally on the cycle whose clock edge wraps the count.
module tick_gen
  import onehot_scan_decoder_pkg::*;
#(
  parameter int PRESCALE = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int                CNT_W    = clog2(PRESCALE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = run & ~clr & (cnt_q == LAST_CNT);

  // NOTE: assign a default first so every path drives cnt_d and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered binary-to-one-hot digit selector with direct and autonomous scan modes.
// Define SCAN_BLANK_EN to blank y for one cycle after every scan step (anti-ghosting).
module onehot_scan_decoder
  import onehot_scan_decoder_pkg::*;
#(
  parameter int SEL_W    = 2,
  parameter int NUM_OUT  = 4,
  parameter int PRESCALE = 100000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [0:NUM_OUT-1] y,
  output logic [SEL_W-1:0]   idx,
  output logic               tick,
  output logic               oor
);

  localparam logic [SEL_W:0]   NUM_OUT_V = (SEL_W + 1)'(NUM_OUT);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_OUT - 1);

  logic [0:NUM_OUT-1] y_q, y_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               tick_q, tick_d;
  logic               oor_q, oor_d;
  logic               wrap;
  logic               scan_clr;
  logic               scan_run;

  function automatic logic [0:NUM_OUT-1] decode(input logic [SEL_W-1:0] i);
    return NUM_OUT'(onehot(32'(i)) >> (MAX_OUT - NUM_OUT));
  endfunction

  // Holding the prescaler clear outside scan mode makes every scan entry start from 0.
  assign scan_clr = (mode == MODE_DIRECT);
  assign scan_run = en & (mode == MODE_SCAN);

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (scan_clr),
    .run   (scan_run),
    .tick  (wrap)
  );

  always_comb begin
    y_d    = '0;
    idx_d  = idx_q;
    tick_d = 1'b0;
    oor_d  = 1'b0;
    if (en) begin
      if (mode == MODE_DIRECT) begin
        if ({1'b0, sel} < NUM_OUT_V) begin
          y_d   = decode(sel);
          idx_d = sel;
        end else begin
          oor_d = 1'b1;
        end
      end else if (wrap) begin
        idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + SEL_W'(1);
        tick_d = 1'b1;
`ifdef SCAN_BLANK_EN
        y_d    = '0;
`else
        y_d    = decode(idx_d);
`endif
      end else begin
        y_d = decode(idx_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= '0;
      idx_q  <= '0;
      tick_q <= 1'b0;
      oor_q  <= 1'b0;
    end else begin
      y_q    <= y_d;
      idx_q  <= idx_d;
      tick_q <= tick_d;
      oor_q  <= oor_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign tick = tick_q;
  assign oor  = oor_q;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Scoreboard bench: two decoders (NUM_OUT=4 and NUM_OUT=3, PRESCALE=4) share
// stimulus; a reference model queues expected outputs, a monitor checks them.
module tb_onehot_scan_decoder;

  localparam int PRESCALE = 4;
  localparam int SEL_W    = 2;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             mode;
  logic [SEL_W-1:0] sel;

  logic [0:3]       y4;
  logic [SEL_W-1:0] idx4;
  logic             tick4;
  logic             oor4;
  logic [0:2]       y3;
  logic [SEL_W-1:0] idx3;
  logic             tick3;
  logic             oor3;

  onehot_scan_decoder #(.SEL_W(SEL_W), .NUM_OUT(4), .PRESCALE(PRESCALE)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
    .y(y4), .idx(idx4), .tick(tick4), .oor(oor4)
  );

  onehot_scan_decoder #(.SEL_W(SEL_W), .NUM_OUT(3), .PRESCALE(PRESCALE)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
    .y(y3), .idx(idx3), .tick(tick3), .oor(oor3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int y;
    int idx;
    int tick;
    int oor;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  exp_t e4;
  exp_t e3;

  int n_of[2] = '{4, 3};
  int m_idx[2];
  int m_steps[2];
  int checks = 0;
  int passes = 0;
  int cur_mode;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  // Expected y value with element i of [0:n-1] set: element 0 is the leftmost bit.
  function automatic int oh(input int n, input int i);
    return 1 << (n - 1 - i);
  endfunction

  // One clock edge of the behavioural model: scan steps every PRESCALE counted cycles.
  task automatic model_step(input int k, input int e, input int m, input int s, output exp_t r);
    int n;
    n = n_of[k];
    r = '{0, 0, 0, 0};
    if (m == 0) m_steps[k] = 0;
    if (e != 0) begin
      if (m == 0) begin
        if (s < n) begin
          m_idx[k] = s;
          r.y = oh(n, s);
        end else begin
          r.oor = 1;
        end
      end else begin
        m_steps[k] = m_steps[k] + 1;
        if (m_steps[k] == PRESCALE) begin
          m_steps[k] = 0;
          m_idx[k] = (m_idx[k] + 1) % n;
          r.tick = 1;
`ifdef SCAN_BLANK_EN
          r.y = 0;
`else
          r.y = oh(n, m_idx[k]);
`endif
        end else begin
          r.y = oh(n, m_idx[k]);
        end
      end
    end
    r.idx = m_idx[k];
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = 0;
      m_steps[k] = 0;
    end
  endtask

  task automatic push_step(input int e, input int m, input int s);
    exp_t r;
    en = (e != 0);
    mode = (m != 0);
    sel = SEL_W'(s);
    cur_mode = m;
    model_step(0, e, m, s, r);
    q4.push_back(r);
    model_step(1, e, m, s, r);
    q3.push_back(r);
  endtask

  task automatic drive(input int e, input int m, input int s);
    @(negedge clk);
    push_step(e, m, s);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_y4"}, int'(y4), 0);
    check({tag, "_idx4"}, int'(idx4), 0);
    check({tag, "_tick4"}, int'(tick4), 0);
    check({tag, "_oor4"}, int'(oor4), 0);
    check({tag, "_y3"}, int'(y3), 0);
    check({tag, "_idx3"}, int'(idx3), 0);
  endtask

  // Release on a falling edge and queue that cycle as an idle (en=0) step.
  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    push_step(0, 0, 0);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (q4.size() > 0) begin
      e4 = q4.pop_front();
      check("y4", int'(y4), e4.y);
      check("idx4", int'(idx4), e4.idx);
      check("tick4", int'(tick4), e4.tick);
      check("oor4", int'(oor4), e4.oor);
      check("y4_onehot", int'($countones(y4) <= 1), 1);
    end
    if (q3.size() > 0) begin
      e3 = q3.pop_front();
      check("y3", int'(y3), e3.y);
      check("idx3", int'(idx3), e3.idx);
      check("tick3", int'(tick3), e3.tick);
      check("oor3", int'(oor3), e3.oor);
      check("y3_onehot", int'($countones(y3) <= 1), 1);
    end
  end

  initial begin
    rst_n = 1'b1;
    en = 1'b0;
    mode = 1'b0;
    sel = '0;
    cur_mode = 0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_state("por");
    release_reset();

    // Direct decode of every select value, then out-of-range for the 3-output instance.
    for (int s = 0; s < 4; s++) drive(1, 0, s);
    drive(1, 0, 1);
    drive(1, 0, 3);
    drive(1, 0, 1);
    for (int i = 0; i < 16; i++) drive(1, 0, int'($urandom_range(0, 3)));

    // Free-running scan.
    for (int i = 0; i < 20; i++) drive(1, 1, int'($urandom_range(0, 3)));

    // Freeze exactly on a wrap cycle, then resume.
    for (int i = 0; i < 2 * PRESCALE && m_steps[0] != PRESCALE - 1; i++) drive(1, 1, 0);
    check("freeze_align", m_steps[0], PRESCALE - 1);
    drive(0, 1, 0);
    drive(0, 1, 2);
    for (int i = 0; i < 12; i++) drive(1, 1, 0);

    // Asynchronous reset in the middle of a scan.
    drive(1, 0, 0);
    for (int i = 0; i < 9; i++) drive(1, 1, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    en = 1'b0;
    mode = 1'b0;
    #1 check_reset_state("async");
    release_reset();
    drive(1, 0, 2);
    drive(1, 1, 0);

    // Random en/mode/sel mix with sticky modes so scans run long enough to wrap.
    for (int i = 0; i < 400; i++) begin
      int e;
      int m;
      e = ($urandom_range(0, 9) != 0) ? 1 : 0;
      m = cur_mode;
      if ($urandom_range(0, 11) == 0) m = 1 - cur_mode;
      drive(e, m, int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 10 && (q4.size() + q3.size()) > 0; i++) begin
      @(posedge clk);
      #2;
    end
    check("queue_drained", q4.size() + q3.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
